// File: rtl/xs3_pkg.sv
// xs3_pkg: constants shared by the packed-BCD to excess-3 sequencer.
//   State encoding (IDLE/CONV/DONE), nibble and XS3 slice widths,
//   the excess-3 offset and the largest legal BCD digit.
package xs3_pkg;

  localparam int NIB_W = 4;
  localparam int XS3_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [XS3_W-1:0] XS3_OFFSET = 5'd3;
  localparam logic [NIB_W-1:0] BCD_MAX    = 4'd9;

  // True when a nibble is not a legal BCD digit (10..15).
  function automatic logic bcd_invalid(input logic [NIB_W-1:0] nib);
    return nib > BCD_MAX;
  endfunction

endpackage

// File: rtl/bin_to_xs3.sv
// bin_to_xs3: combinational 4-bit binary to 5-bit excess-3 converter.
//   a : 4-bit input value
//   y : a + 3, 5 bits wide so inputs 13..15 do not wrap
module bin_to_xs3
  import xs3_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  output logic [XS3_W-1:0] y
);

  assign y = {1'b0, a} + XS3_OFFSET;

endmodule

// File: rtl/xs3_digit_sequencer.sv
// xs3_digit_sequencer: converts DIGITS packed BCD nibbles to excess-3 by
// time-sharing one bin_to_xs3 converter, one nibble per clock.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   start : conversion request, sampled only in IDLE
//   din   : packed BCD input, digit k = din[4k+3:4k], digit 0 first
//   busy  : high during CONV
//   done  : one-cycle pulse when dout is valid
//   dout  : packed excess-3 result, slice k = dout[5k+4:5k]
//   err   : sticky invalid-BCD flag, only when XS3_SEQ_BCD_CHECK_EN is
//           defined; otherwise tied to 0
//
// state | meaning
// IDLE  | waiting for start; dout/err hold last result
// CONV  | one nibble converted and stored per clock
// DONE  | single-cycle completion pulse, then back to IDLE
module xs3_digit_sequencer
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4,
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NIB_W*DIGITS-1:0] din,
  output logic                    busy,
  output logic                    done,
  output logic [XS3_W*DIGITS-1:0] dout,
  output logic                    err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NIB_W*DIGITS-1:0] din_q, din_d;
  logic [XS3_W*DIGITS-1:0] dout_q, dout_d;
  logic [NIB_W-1:0]        cur_nib;
  logic [XS3_W-1:0]        cur_xs3;

  // Converter always sees the latched word, never live din.
  always_comb begin
    cur_nib = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) cur_nib = din_q[k*NIB_W +: NIB_W];
    end
  end

  bin_to_xs3 u_conv (
    .a (cur_nib),
    .y (cur_xs3)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    din_d   = din_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          din_d   = din;
          dout_d  = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (idx_q == IDX_W'(k)) dout_d[k*XS3_W +: XS3_W] = cur_xs3;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

`ifdef XS3_SEQ_BCD_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) err_d = 1'b0;
    else if (state_q == CONV && bcd_invalid(cur_nib)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state_q == CONV);
  assign done = (state_q == DONE);
  assign dout = dout_q;

endmodule

// File: tb/tb_xs3_digit_sequencer.sv
module tb_xs3_digit_sequencer;

  localparam int DIGITS = 4;

  logic                clk;
  logic                rst;
  logic                start;
  logic [4*DIGITS-1:0] din;
  logic                busy;
  logic                done;
  logic [5*DIGITS-1:0] dout;
  logic                err;

  int checks;
  int errors;

  xs3_digit_sequencer #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each nibble plus three, placed at 5-bit stride, no carries.
  function automatic logic [5*DIGITS-1:0] model_dout(input logic [4*DIGITS-1:0] d);
    longint r;
    longint n;
    r = 0;
    for (int k = 0; k < DIGITS; k++) begin
      n = longint'((d >> (4 * k)) & 16'hF);
      r = r + ((n + 3) << (5 * k));
    end
    return (5*DIGITS)'(r);
  endfunction

  function automatic logic model_err(input logic [4*DIGITS-1:0] d);
    logic e;
    e = 1'b0;
`ifdef XS3_SEQ_BCD_CHECK_EN
    for (int k = 0; k < DIGITS; k++) begin
      if (((d >> (4 * k)) & 16'hF) > 9) e = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Caller is in IDLE, 1 time unit after an edge. Leaves start as given by
  // hold_start after acceptance; ends in IDLE 1 unit after the DONE-exit edge.
  task automatic do_conv(input string tag, input logic [4*DIGITS-1:0] d,
                         input logic [5*DIGITS-1:0] exp_dout, input logic exp_err,
                         input logic hold_start);
    start = 1'b1;
    din   = d;
    tick();
    start = hold_start;
    din   = 16'($urandom);
    for (int i = 0; i < DIGITS; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    tick();
    chk({tag, "_done_once"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  logic exp_a0_err;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    din    = '0;
`ifdef XS3_SEQ_BCD_CHECK_EN
    exp_a0_err = 1'b1;
`else
    exp_a0_err = 1'b0;
`endif

    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_hold", 32'(busy), 32'd0);

    do_conv("nominal", 16'h1234, 20'h214C7, 1'b0, 1'b0);
    tick();
    chk("dout_holds", 32'(dout), 32'h214C7);

    do_conv("zeros", 16'h0000, 20'h18C63, 1'b0, 1'b0);
    do_conv("nines", 16'h9999, 20'h6318C, 1'b0, 1'b0);
    do_conv("inval", 16'h00A0, 20'h18DA3, exp_a0_err, 1'b0);

    // Reset in the middle of a conversion.
    start = 1'b1;
    din   = 16'h1234;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    tick();
    chk("midrst_idle", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    do_conv("post_rst", 16'h1234, 20'h214C7, 1'b0, 1'b0);

    // Requests during CONV/DONE are ignored; held start then fires in IDLE.
    start = 1'b1;
    din   = 16'h1234;
    tick();
    din = 16'h5678;
    for (int i = 0; i < DIGITS; i++) begin
      chk("ign_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_dout", 32'(dout), 32'h214C7);
    tick();
    chk("ign_one_pulse", 32'(done), 32'd0);
    chk("ign_idle", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      chk("new_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("new_done", 32'(done), 32'd1);
    chk("new_dout", 32'(dout), 32'(model_dout(16'h5678)));
    tick();

    // Back-to-back with start held high; each do_conv spans DIGITS+2 edges.
    for (int n = 0; n < 20; n++) begin
      logic [4*DIGITS-1:0] d;
      d = 16'($urandom);
      do_conv("b2b", d, model_dout(d), model_err(d), 1'b1);
    end
    start = 1'b0;
    tick();
    tick();
    chk("final_idle", 32'(busy | done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
